// File: rtl/fact_seq.sv
// Bus-master sequencer that runs one factorial-accelerator transaction per start request:
// write n, write go=1, poll status, read result, write go=0.
//
// state  | meaning
// IDLE   | waiting for start, bus parked on status
// WR_N   | writing latched operand to a=0
// WR_GO  | writing go=1, launches the accelerator
// SETTLE | dead cycle for the go write to take effect
// WAIT   | polling status for err/done, bounded by TIMEOUT
// RD_RES | capturing the result from a=3
// CLR_GO | writing go=0 before returning to IDLE
module fact_seq #(
    parameter int TIMEOUT = 1024,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  n_in,
    input  logic [31:0] rd,
    output logic [1:0]  a,
    output logic        we,
    output logic [3:0]  wd,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] result,
    output logic        err,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        WR_N,
        WR_GO,
        SETTLE,
        WAIT,
        RD_RES,
        CLR_GO
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    a_nxt;
    logic          we_nxt;
    logic [3:0]    n_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= 2'd0;
            we    <= 1'b0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            we    <= we_nxt;
        end
    end

    // Bus address/strobe are registered from the next state so they carry no
    // decode glitches and still read 0 while reset is held.
    always_comb begin
        state_nxt = state;
        a_nxt     = 2'd2;
        we_nxt    = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = WR_N;
            WR_N:    state_nxt = WR_GO;
            WR_GO:   state_nxt = SETTLE;
            SETTLE:  state_nxt = WAIT;
            WAIT: begin
                if (rd[1])
                    state_nxt = CLR_GO;
                else if (rd[0])
                    state_nxt = RD_RES;
                else if (cnt == LAST)
                    state_nxt = CLR_GO;
            end
            RD_RES:  state_nxt = CLR_GO;
            CLR_GO:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        case (state_nxt)
            WR_N: begin
                a_nxt  = 2'd0;
                we_nxt = 1'b1;
            end
            WR_GO, CLR_GO: begin
                a_nxt  = 2'd1;
                we_nxt = 1'b1;
            end
            RD_RES:  a_nxt = 2'd3;
            default: a_nxt = 2'd2;
        endcase
    end

    always_comb begin
        wd = 4'd0;
        case (state)
            WR_N:    wd = n_q;
            WR_GO:   wd = 4'd1;
            default: wd = 4'd0;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q       <= 4'd0;
            cnt       <= '0;
            result    <= 32'd0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            res_valid <= (state == RD_RES);
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q     <= n_in;
                        err     <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                SETTLE: cnt <= '0;
                WAIT: begin
                    // err wins over done when both are reported together
                    if (rd[1])
                        err <= 1'b1;
                    else if (rd[0])
                        cnt <= cnt;
                    else if (cnt == LAST)
                        timeout <= 1'b1;
                    else
                        cnt <= cnt + 1'b1;
                end
                RD_RES: result <= rd;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_seq.sv
// Self-checking bench for fact_seq: behavioural accelerator model on the bus,
// table-driven transactions, hand-written corner sequences and randomized runs.
module tb_fact_seq;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  n_in;
    logic [31:0] rd;
    logic [1:0]  a;
    logic        we;
    logic [3:0]  wd;
    logic        busy;
    logic        res_valid;
    logic [31:0] result;
    logic        err;
    logic        timeout;

    fact_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .rd(rd),
        .a(a), .we(we), .wd(wd), .busy(busy), .res_valid(res_valid),
        .result(result), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // accelerator model: mode 0=done, 1=err, 2=never finishes, 3=err+done
    int cfg_mode = 0;
    int cfg_delay = 1;
    logic [3:0] acc_n;
    logic acc_go, acc_done, acc_err, acc_run;
    int acc_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_n <= 4'd0; acc_go <= 1'b0; acc_done <= 1'b0; acc_err <= 1'b0;
            acc_run <= 1'b0; acc_cnt <= 0;
        end else begin
            if (we && a == 2'd0) acc_n <= wd;
            if (we && a == 2'd1) begin
                acc_go <= wd[0];
                if (wd[0]) begin
                    acc_run <= 1'b1; acc_cnt <= cfg_delay;
                    acc_done <= 1'b0; acc_err <= 1'b0;
                end
            end else if (acc_run) begin
                if (cfg_mode != 2 && acc_cnt <= 1) begin
                    acc_run  <= 1'b0;
                    acc_done <= (cfg_mode == 0 || cfg_mode == 3);
                    acc_err  <= (cfg_mode == 1 || cfg_mode == 3);
                end else if (acc_cnt > 1) begin
                    acc_cnt <= acc_cnt - 1;
                end
            end
        end
    end

    always_comb begin
        case (a)
            2'd0:    rd = {28'd0, acc_n};
            2'd1:    rd = {31'd0, acc_go};
            2'd2:    rd = {30'd0, acc_err, acc_done};
            default: rd = fact(acc_n);
        endcase
    end

    logic [5:0] wq[$];
    int rv_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (we) wq.push_back({a, wd});
            if (res_valid) rv_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic do_txn(input string nm, input logic [3:0] n, input int mode, input int delay,
                          input bit hammer, input logic [31:0] exp_res, input bit exp_err,
                          input bit exp_to, input int exp_busy);
        int k;
        logic [17:0] wr_got;
        cfg_mode = mode;
        cfg_delay = delay;
        @(negedge clk);
        wq.delete();
        rv_cnt = 0;
        busy_cnt = 0;
        start = 1'b1;
        n_in = n;
        @(negedge clk);
        chk({nm, " flags cleared"}, {62'd0, err, timeout}, 64'd0);
        if (!hammer) start = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            if (hammer) begin
                start = 1'b1;
                n_in = 4'($urandom);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (k >= 200) chk({nm, " busy bound"}, 64'(k), 64'd0);
        chk({nm, " result"}, 64'(result), 64'(exp_res));
        chk({nm, " err/timeout"}, {62'd0, err, timeout}, {62'd0, exp_err, exp_to});
        chk({nm, " res_valid pulses"}, 64'(rv_cnt), (!exp_err && !exp_to) ? 64'd1 : 64'd0);
        chk({nm, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
        wr_got = (wq.size() == 3) ? {wq[0], wq[1], wq[2]} : 18'h3FFFF;
        chk({nm, " bus writes"}, 64'(wr_got), 64'({2'd0, n, 2'd1, 4'd1, 2'd1, 4'd0}));
    endtask

    typedef struct {
        logic [3:0]  n;
        int          mode;
        int          delay;
        logic [31:0] exp_res;
        bit          exp_err;
        bit          exp_to;
        int          exp_busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] last_good;
        vecs[0] = '{4'd5,  0, 10, 32'd120,       1'b0, 1'b0, 15};
        vecs[1] = '{4'd0,  0, 1,  32'd1,         1'b0, 1'b0, 6};
        vecs[2] = '{4'd12, 0, 3,  32'h1C8CFC00,  1'b0, 1'b0, 8};
        vecs[3] = '{4'd13, 1, 4,  32'h1C8CFC00,  1'b1, 1'b0, 8};
        vecs[4] = '{4'd7,  0, 16, 32'd5040,      1'b0, 1'b0, 21};
        vecs[5] = '{4'd8,  0, 17, 32'd5040,      1'b0, 1'b1, 20};
        vecs[6] = '{4'd2,  3, 2,  32'd5040,      1'b1, 1'b0, 6};
        vecs[7] = '{4'd4,  2, 1,  32'd5040,      1'b0, 1'b1, 20};
        vecs[8] = '{4'd3,  0, 5,  32'd6,         1'b0, 1'b0, 10};

        rst = 1'b1;
        start = 1'b0;
        n_in = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset outputs", 64'({a, we, wd, busy, res_valid, result, err, timeout}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle bus", {61'd0, a, busy}, {61'd0, 2'd2, 1'b0});

        for (int i = 0; i < 9; i++)
            do_txn($sformatf("vec%0d", i), vecs[i].n, vecs[i].mode, vecs[i].delay, 1'b0,
                   vecs[i].exp_res, vecs[i].exp_err, vecs[i].exp_to, vecs[i].exp_busy);

        do_txn("hammer", 4'd6, 0, 4, 1'b1, 32'd720, 1'b0, 1'b0, 9);

        // async reset in the middle of WAIT
        cfg_mode = 2;
        @(negedge clk);
        start = 1'b1;
        n_in = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("in wait before reset", {61'd0, a, busy}, {61'd0, 2'd2, 1'b1});
        #2 rst = 1'b1;
        #1 chk("mid-wait reset", 64'({a, we, wd, busy, res_valid, result, err, timeout}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_txn("after reset", 4'd3, 0, 2, 1'b0, 32'd6, 1'b0, 1'b0, 7);

        last_good = 32'd6;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] n;
            int mode, d, bc;
            bit e, t;
            n = 4'($urandom);
            mode = int'($urandom_range(0, 3));
            d = int'($urandom_range(1, 20));
            e = 1'b0;
            t = 1'b0;
            if (mode == 2 || d > TO) begin
                t = 1'b1;
                bc = 4 + TO;
            end else if (mode == 0) begin
                last_good = fact(n);
                bc = 5 + d;
            end else begin
                e = 1'b1;
                bc = 4 + d;
            end
            do_txn($sformatf("rand%0d", i), n, mode, d, 1'b0, last_good, e, t, bc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fact_seq.md
Name: fact_seq

Overview:
- Autonomous bus-master sequencer that drives the factorial accelerator peripheral's register port and consumes its read data.
- On a start request it runs one full transaction:
  - write n
  - write go=1
  - poll status until done or err
  - read the result
  - write go=0
- Sits between board-level controls (switches/button, debounced upstream) and the accelerator's a/we/wd/rd port. Lets the accelerator run without the MIPS core.

Parameters:
- TIMEOUT, 1024, maximum poll cycles in WAIT before giving up (must be ≥ 2).
- CW, $clog2(TIMEOUT+1), poll-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request; sampled only in IDLE
- n_in  input  4  operand; latched on accepted start
- rd  input  32  accelerator read data (combinational function of a)
- a  output  2  accelerator register address: 0=n, 1=go, 2=status{err,done}, 3=result
- we  output  1  accelerator write enable
- wd  output  4  accelerator write data
- busy  output  1  high from the cycle after an accepted start until return to IDLE
- res_valid  output  1  one-cycle pulse when result is updated
- result  output  32  last successful factorial, held
- err  output  1  sticky error flag for last transaction
- timeout  output  1  sticky timeout flag for last transaction

Behaviour:
- Reset (async, any state): state=IDLE, a=0, we=0, wd=0, busy=0, res_valid=0, result=0, err=0, timeout=0, n latch=0, poll counter=0.
- All outputs are registered or decoded from state only; no combinational path from rd to a/we/wd.
- States and actions (a/we/wd per state):
  - IDLE: a=2, we=0, busy=0. start=1 → latch n_in, clear err and timeout → WR_N.
  - WR_N: a=0, we=1, wd=n latch → WR_GO.
  - WR_GO: a=1, we=1, wd=4'b0001 → SETTLE. This write clears the accelerator's done/err and launches it.
  - SETTLE: a=2, we=0; one dead cycle so the go pulse propagates. Poll counter=0 → WAIT.
  - WAIT: a=2, we=0. rd sampled at the clock edge:
    - rd[1]=1 → set err → CLR_GO. err has priority over done if both are 1.
    - else rd[0]=1 → RD_RES.
    - else counter==TIMEOUT-1 → set timeout → CLR_GO.
    - else counter+1.
  - RD_RES: a=3, we=0. result ← rd, res_valid=1 for exactly this edge's following cycle → CLR_GO.
  - CLR_GO: a=1, we=1, wd=0 → IDLE.
- Latency: a successful transaction with a done seen on the first WAIT sample takes 6 cycles from the start edge to the IDLE return (WR_N, WR_GO, SETTLE, WAIT, RD_RES, CLR_GO). res_valid rises the cycle after the RD_RES edge.
- start in any non-IDLE state is ignored (not queued). n_in changes during a transaction have no effect.
- result is not modified on err or timeout. It keeps the previous successful value.
- err and timeout stay set until the next accepted start or reset.
- Reset mid-transaction: immediate IDLE with we=0. The accelerator is reset by the same rst, so no cleanup write is required.
- Counter never wraps: it saturates the transition at TIMEOUT-1.
- busy=1 in every state except IDLE.

Test Plan:
- n_in=5, start pulse, accelerator model returns done after 10 cycles with rd=120 at a=3 → bus trace WR n=5, WR go=1, polls, read a=3, WR go=0. Then result=120, res_valid single pulse, err=0, busy low 1 cycle after CLR_GO.
- n_in=0 → result=1. Then n_in=12 → result=479001600 (0x1C8CFC00); res_valid pulses once per run.
- n_in=13 with model asserting status=2'b10 → err=1, timeout=0, result still 479001600, no res_valid, CLR_GO write observed.
- Model that never asserts done, TIMEOUT=16 → timeout=1 exactly 16 WAIT cycles after SETTLE, result unchanged, then IDLE. Next start clears timeout.
- start pulsed every cycle during a transaction with n_in toggling → only one transaction. The n written equals the value at the accepted start.
- rst asserted mid-WAIT (asynchronously, between edges) → we=0, busy=0, all outputs 0 immediately. A subsequent start with n_in=3 yields result=6.
